ysyx_23060201_ifu_axi: RTL and testbench
========================================

# ysyx_23060201_ifu_axi

Multi-cycle instruction fetch unit that replaces the combinational fetch path of the single-cycle core. It owns the architectural PC and fetches each instruction over an AXI4-Lite read channel (AR/R only). It presents `{pc, inst}` to the decode stage with a valid/ready handshake. It then waits for the execute stage to return the next PC before issuing the next fetch.

## Interface
Parameters:
- `RESET_PC`, default `32'h8000_0000`: PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `arvalid`  out  1  read-address valid.
- `arready`  in  1  read-address ready.
- `araddr`  out  32  fetch address, equal to the current PC.
- `rvalid`  in  1  read-data valid.
- `rready`  out  1  read-data ready.
- `rdata`  in  32  instruction word.
- `rresp`  in  2  read response; `2'b00` is OKAY.
- `out_valid`  out  1  instruction valid to decode.
- `out_ready`  in  1  decode accepts the instruction.
- `out_pc`  out  32  PC of the presented instruction.
- `out_inst`  out  32  presented instruction word.
- `wb_valid`  in  1  execute has finished; `wb_dnpc` is valid.
- `wb_dnpc`  in  32  next PC from execute.
- `fault`  out  1  access fault, sticky. Present only with `YSYX_23060201_IFU_FAULT_EN`.

## Operation
- FSM states:
  - `S_IDLE`: unconditionally goes to `S_REQ`.
  - `S_REQ`: `arvalid`=1; on `arvalid & arready` go to `S_WAIT`.
  - `S_WAIT`: `rready`=1; on `rvalid` capture `rdata` into the instruction register and go to `S_HOLD`.
  - `S_HOLD`: `out_valid`=1; on `out_ready` go to `S_EXEC`.
  - `S_EXEC`: on `wb_valid`, load PC from `wb_dnpc` and go to `S_REQ`.
- `arvalid`, `rready` and `out_valid` are pure decodes of the state register. They have no combinational path from any input.
- `araddr` = PC register. The PC changes only in `S_EXEC` on `wb_valid`, so `araddr` is stable while `arvalid` is high.
- Once raised, `arvalid` is never dropped before `arready` (AXI rule). `out_valid` is never dropped before `out_ready`.
- `out_pc` = PC register. `out_inst` = instruction register. Both are stable for as long as `out_valid` is high.
- `wb_valid` is ignored in every state except `S_EXEC`. `arready` is ignored outside `S_REQ`. `rvalid` is ignored outside `S_WAIT`.
- No outstanding-transaction tracking. The memory slave shares `rst`, so no R beat can arrive after a reset.
- `wb_dnpc[1:0]` is passed through unmodified. Alignment is the execute stage's responsibility.

## Timing
- Reset values:
  - state = `S_IDLE`, PC = `RESET_PC`, instruction register = `32'h0000_0013` (nop).
  - `arvalid` = `rready` = `out_valid` = 0.
  - `fault` = 0.
- First `arvalid` is asserted in the second cycle after `rst` deasserts.
- Best-case loop, zero-wait slave with `out_ready` and `wb_valid` tied high, 4 cycles per instruction:
  - cycle 0: AR handshake.
  - cycle 1: R handshake.
  - cycle 2: `out_valid`.
  - cycle 3: `S_EXEC`, PC updates.
  - cycle 4: next AR.
- Each cycle of `arready`, `rvalid`, `out_ready` or `wb_valid` low adds exactly one cycle in the corresponding state.
- `rst` asserted in any state forces the reset values at the next edge. Any in-flight handshake is abandoned.

## Configuration
- `YSYX_23060201_IFU_FAULT_EN` defined:
  - On the R handshake with `rresp != 2'b00`, go to `S_FAULT` instead of `S_HOLD`, and set `fault`.
  - `S_FAULT` is terminal: all handshake outputs are 0 and `fault` = 1 until `rst`.
- Macro undefined:
  - `rresp` is ignored and `rdata` is captured as normal.
  - The `fault` port and `S_FAULT` state are not compiled in.

## Structure
- Shared package `ysyx_23060201_pkg` holds:
  - the state enum (`S_IDLE`, `S_REQ`, `S_WAIT`, `S_HOLD`, `S_EXEC`, `S_FAULT`);
  - `RESP_OKAY = 2'b00`;
  - `NOP_INST = 32'h0000_0013`;
  - the default reset PC.
- Single module. No sub-module: the FSM, PC register and instruction register are too tightly coupled to split.

## Test plan
- Reset, then zero-wait slave returning `32'h0010_0093` at `0x8000_0000`, `out_ready`=1, `wb_valid`=1 with `wb_dnpc=0x8000_0004`:
  - `araddr=0x8000_0000` in cycle 1 after reset release;
  - `out_inst=0x0010_0093`, `out_pc=0x8000_0000` in cycle 3;
  - next `araddr=0x8000_0004` in cycle 5.
- `arready` held low 3 cycles: `arvalid` stays 1 and `araddr` stays constant for all 4 cycles; no R beat is accepted early.
- `out_ready` low 5 cycles while `rvalid` toggles: `out_valid`, `out_pc` and `out_inst` are unchanged, `rready`=0, and no second AR is issued.
- `wb_valid` pulsed during `S_HOLD`, then `wb_dnpc=0x8000_0100` in `S_EXEC`: the first pulse is ignored, and the next `araddr` is `0x8000_0100`.
- `rst` asserted one cycle into `S_WAIT`: the next edge gives `arvalid`=`rready`=`out_valid`=0, and the next fetch is at `0x8000_0000`.
- With the macro defined, `rresp=2'b10`: `fault`=1 the next cycle, `out_valid` never rises, and no further AR occurs until `rst`. Without the macro, the same stimulus delivers `rdata` normally.

Source files
------------

// File: rtl/ysyx_23060201_pkg.sv
// Shared definitions for the ysyx_23060201 instruction fetch unit.
// Holds the fetch FSM state encoding, the AXI OKAY response code,
// the reset value of the instruction register (a canonical nop) and
// the default reset PC.
package ysyx_23060201_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_EXEC,
    S_FAULT
  } state_e;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060201_ifu_axi.sv
// ysyx_23060201_ifu_axi -- multi-cycle instruction fetch unit.
//
// Owns the architectural PC, fetches one instruction at a time over an
// AXI4-Lite read channel (AR/R), presents {pc, inst} to decode with a
// valid/ready handshake and then waits for execute to return the next PC.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   arvalid/arready      read-address handshake, araddr = PC
//   rvalid/rready        read-data handshake, rdata/rresp from slave
//   out_valid/out_ready  instruction handshake to decode, out_pc/out_inst
//   wb_valid, wb_dnpc    next PC from execute
//   fault                sticky access fault (only with the macro below)
//
// Build option:
//   YSYX_23060201_IFU_FAULT_EN  a non-OKAY read response parks the FSM in
//                               S_FAULT and raises fault until reset.
module ysyx_23060201_ifu_axi
  import ysyx_23060201_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        wb_valid,
`ifdef YSYX_23060201_IFU_FAULT_EN
  input  logic [31:0] wb_dnpc,
  output logic        fault
`else
  input  logic [31:0] wb_dnpc
`endif
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (arready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rvalid) begin
`ifdef YSYX_23060201_IFU_FAULT_EN
          if (rresp != RESP_OKAY) begin
            state_d = S_FAULT;
          end else begin
            inst_d  = rdata;
            state_d = S_HOLD;
          end
`else
          inst_d  = rdata;
          state_d = S_HOLD;
`endif
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        // The only place the PC moves, so araddr is stable across AR.
        if (wb_valid) begin
          pc_d    = wb_dnpc;
          state_d = S_REQ;
        end
      end
`ifdef YSYX_23060201_IFU_FAULT_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decode the state register only: no input-to-output path.
  assign arvalid   = (state_q == S_REQ);
  assign rready    = (state_q == S_WAIT);
  assign out_valid = (state_q == S_HOLD);
  assign araddr    = pc_q;
  assign out_pc    = pc_q;
  assign out_inst  = inst_q;

`ifdef YSYX_23060201_IFU_FAULT_EN
  assign fault = (state_q == S_FAULT);
`else
  // Response code is deliberately ignored when fault handling is off.
  logic unused_rresp;
  assign unused_rresp = ^rresp;
`endif

endmodule

// File: tb/tb_ysyx_23060201_ifu_axi.sv
module tb_ysyx_23060201_ifu_axi;
  import ysyx_23060201_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;
  logic        wb_valid;
  logic [31:0] wb_dnpc;
`ifdef YSYX_23060201_IFU_FAULT_EN
  logic        fault;
`endif

  ysyx_23060201_ifu_axi #(.RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .rresp     (rresp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .wb_valid  (wb_valid),
`ifdef YSYX_23060201_IFU_FAULT_EN
    .wb_dnpc   (wb_dnpc),
    .fault     (fault)
`else
    .wb_dnpc   (wb_dnpc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ar_wait;
    int          r_wait;
    int          out_wait;
    int          wb_wait;
    logic [1:0]  resp;
    logic [31:0] dnpc;
    logic [31:0] inst;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_pc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; arready = 1'b0; rvalid = 1'b0; out_ready = 1'b0;
    wb_valid = 1'b0; rdata = '0; rresp = '0; wb_dnpc = '0;
    step();
    step();
    chk1("rst_arvalid", arvalid, 1'b0);
    chk1("rst_rready", rready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk32("rst_araddr", araddr, RST_PC);
    chk32("rst_out_inst", out_inst, 32'h0000_0013);
`ifdef YSYX_23060201_IFU_FAULT_EN
    chk1("rst_fault", fault, 1'b0);
`endif
    rst = 1'b0;
    sb.delete();
    model_pc = RST_PC;
    // First cycle after release is still S_IDLE.
    chk1("idle_arvalid", arvalid, 1'b0);
    step();
  endtask

  // One full fetch: each phase lasts exactly wait+1 cycles.
  task automatic do_insn(input vec_t v);
    for (int k = 0; k <= v.ar_wait; k++) begin
      chk1("ar_arvalid", arvalid, 1'b1);
      chk32("ar_araddr", araddr, model_pc);
      chk1("ar_rready", rready, 1'b0);
      chk1("ar_out_valid", out_valid, 1'b0);
      arready = (k == v.ar_wait);
      rvalid = 1'($urandom_range(0, 1));
      rdata = 32'hBAD0_0000 | 32'(k);
      rresp = 2'($urandom_range(0, 3));
      out_ready = 1'b1; wb_valid = 1'b1; wb_dnpc = 32'hDEAD_0000;
      step();
    end
    sb.push_back('{pc: model_pc, inst: v.inst});
    for (int k = 0; k <= v.r_wait; k++) begin
      chk1("r_rready", rready, 1'b1);
      chk1("r_arvalid", arvalid, 1'b0);
      chk1("r_out_valid", out_valid, 1'b0);
      arready = 1'b1;
      rvalid = (k == v.r_wait);
      rdata = (k == v.r_wait) ? v.inst : 32'hBAD1_0000;
      rresp = (k == v.r_wait) ? v.resp : 2'b00;
      step();
    end
    for (int k = 0; k <= v.out_wait; k++) begin
      chk1("hold_out_valid", out_valid, 1'b1);
      chk1("hold_arvalid", arvalid, 1'b0);
      chk1("hold_rready", rready, 1'b0);
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty actual=0 required=1");
      end else begin
        chk32("hold_out_pc", out_pc, sb[0].pc);
        chk32("hold_out_inst", out_inst, sb[0].inst);
      end
      out_ready = (k == v.out_wait);
      rvalid = (k % 2 == 0);
      rdata = 32'hBAD2_0000;
      arready = 1'b1;
      // wb pulse during hold must not redirect the PC.
      wb_valid = 1'b1; wb_dnpc = 32'hDEAD_BEE0;
      step();
    end
    if (sb.size() > 0) void'(sb.pop_front());
    for (int k = 0; k <= v.wb_wait; k++) begin
      chk1("ex_arvalid", arvalid, 1'b0);
      chk1("ex_rready", rready, 1'b0);
      chk1("ex_out_valid", out_valid, 1'b0);
      wb_valid = (k == v.wb_wait);
      wb_dnpc = (k == v.wb_wait) ? v.dnpc : 32'hDEAD_0004;
      rvalid = 1'b1; arready = 1'b1; out_ready = 1'b1;
      step();
    end
    model_pc = v.dnpc;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{0, 0, 0, 0, 2'b00, 32'h8000_0004, 32'h0010_0093};
    vecs[1] = '{3, 0, 0, 0, 2'b00, 32'h8000_0008, 32'h0020_0113};
    vecs[2] = '{0, 2, 5, 0, 2'b00, 32'h8000_000C, 32'h0030_0193};
    vecs[3] = '{0, 0, 0, 3, 2'b00, 32'h8000_0100, 32'h0040_0213};
    vecs[4] = '{1, 1, 1, 1, 2'b00, 32'h8000_0102, 32'hFFFF_FFFF};
    vecs[5] = '{2, 3, 1, 2, 2'b00, 32'h8000_0000, 32'h1234_5678};

    do_reset();
    for (int i = 0; i < 6; i++) do_insn(vecs[i]);

    // Reset one cycle into S_WAIT abandons the fetch.
    chk32("mid_araddr", araddr, RST_PC);
    arready = 1'b1; step();
    chk1("mid_rready", rready, 1'b1);
    arready = 1'b0; rvalid = 1'b0; step();
    rst = 1'b1; rvalid = 1'b1; rdata = 32'hBAD3_0000; step();
    chk1("midrst_arvalid", arvalid, 1'b0);
    chk1("midrst_rready", rready, 1'b0);
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk32("midrst_araddr", araddr, RST_PC);
    do_reset();
    do_insn('{0, 0, 0, 0, 2'b00, 32'h8000_0040, 32'h0050_0293});

    // Error response.
`ifdef YSYX_23060201_IFU_FAULT_EN
    chk1("flt_arvalid", arvalid, 1'b1);
    arready = 1'b1; step();
    chk1("flt_rready", rready, 1'b1);
    rvalid = 1'b1; rresp = 2'b10; rdata = 32'h0060_0313; step();
    out_ready = 1'b1; wb_valid = 1'b1; wb_dnpc = 32'h8000_0200;
    for (int k = 0; k < 6; k++) begin
      chk1("flt_fault", fault, 1'b1);
      chk1("flt_out_valid", out_valid, 1'b0);
      chk1("flt_arvalid_off", arvalid, 1'b0);
      chk1("flt_rready_off", rready, 1'b0);
      step();
    end
    do_reset();
    chk1("flt_cleared", fault, 1'b0);
    chk1("flt_refetch", arvalid, 1'b1);
`else
    do_insn('{0, 1, 0, 0, 2'b10, 32'h8000_0044, 32'h0060_0313});
    chk32("resp_next_araddr", araddr, 32'h8000_0044);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
